// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the transmit/receive state encoding.
package uart_pkg;

  // Data bits per 8N1 frame and the width of an index over them.
  localparam int UART_DATA_BITS = 8;
  localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

  // Serial engine states; encodings 5..7 are unused and fall back to IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Occupancy is tracked by a registered count; full and empty come from the
// count so a wrapped pointer pair never looks ambiguous.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Push,
  input  logic [WIDTH-1:0]       i_Data,
  input  logic                   i_Pop,
  output logic [WIDTH-1:0]       o_Data,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A push against a full buffer is dropped even if a pop frees a slot this edge.
  assign w_push = i_Push && !w_full && i_Rst_n;
  assign w_pop  = i_Pop && !w_empty;

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_Data  = r_mem[r_rd_ptr];
  assign o_Full  = w_full;
  assign o_Empty = w_empty;
  assign o_Count = r_count;

endmodule : uart_tx_fifo

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter.
// Bytes are queued in uart_tx_fifo; the serial engine pops one byte per frame
// and drives a registered line: start bit, 8 data bits LSB first, stop bit,
// then a one-cycle CLEANUP that carries the Done pulse.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 435,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_n,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

  localparam int                      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]        LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               r_state;
  logic [CNT_W-1:0]          r_clk_cnt;
  logic [UART_BIT_IDX_W-1:0] r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx_serial;
  logic                      r_tx_active;
  logic                      r_tx_done;

  uart_state_e               w_state_next;
  logic [CNT_W-1:0]          w_clk_cnt_next;
  logic [UART_BIT_IDX_W-1:0] w_bit_idx_next;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic                      w_tx_serial_next;
  logic                      w_tx_active_next;
  logic                      w_tx_done_next;
  logic                      w_clk_last;
  logic                      w_pop;

  logic [UART_DATA_BITS-1:0] w_fifo_data;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Push  (i_Tx_DV),
    .i_Data  (i_Tx_Byte),
    .i_Pop   (w_pop),
    .o_Data  (w_fifo_data),
    .o_Full  (w_fifo_full),
    .o_Empty (w_fifo_empty),
    .o_Count (o_Fifo_Count)
  );

  assign w_clk_last = (r_clk_cnt == LAST_CLK);

  // Next-state and next-output decode for the serial engine.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_next     = r_state;
    w_clk_cnt_next   = r_clk_cnt;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_tx_serial_next = 1'b1;
    w_tx_active_next = 1'b0;
    w_tx_done_next   = 1'b0;
    w_pop            = 1'b0;

    case (r_state)
      IDLE: begin
        w_clk_cnt_next = '0;
        w_bit_idx_next = '0;
        if (!w_fifo_empty) begin
          // Capture the byte now so later input changes cannot touch this frame.
          w_pop            = 1'b1;
          w_shift_next     = w_fifo_data;
          w_state_next     = START;
          w_tx_serial_next = 1'b0;
          w_tx_active_next = 1'b1;
        end
      end

      START: begin
        w_tx_active_next = 1'b1;
        if (w_clk_last) begin
          w_clk_cnt_next   = '0;
          w_state_next     = DATA;
          w_tx_serial_next = r_shift[0];
        end else begin
          w_clk_cnt_next   = r_clk_cnt + CNT_W'(1);
          w_tx_serial_next = 1'b0;
        end
      end

      DATA: begin
        w_tx_active_next = 1'b1;
        w_tx_serial_next = r_shift[0];
        if (w_clk_last) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == LAST_BIT) begin
            w_state_next     = STOP;
            w_tx_serial_next = 1'b1;
          end else begin
            // The shift register always presents the current bit at position 0.
            w_bit_idx_next   = r_bit_idx + UART_BIT_IDX_W'(1);
            w_shift_next     = {1'b0, r_shift[UART_DATA_BITS-1:1]};
            w_tx_serial_next = r_shift[1];
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (w_clk_last) begin
          w_clk_cnt_next = '0;
          w_state_next   = CLEANUP;
          w_tx_done_next = 1'b1;
        end else begin
          w_clk_cnt_next   = r_clk_cnt + CNT_W'(1);
          w_tx_active_next = 1'b1;
        end
      end

      CLEANUP: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next   = IDLE;
        w_clk_cnt_next = '0;
        w_bit_idx_next = '0;
      end
    endcase
  end

  // State and registered-output update; reset aborts any frame in flight.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_tx_serial <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clk_cnt   <= w_clk_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_tx_serial <= w_tx_serial_next;
      r_tx_active <= w_tx_active_next;
      r_tx_done   <= w_tx_done_next;
    end
  end

  assign o_Tx_Ready  = !w_fifo_full;
  assign o_Tx_Serial = r_tx_serial;
  assign o_Tx_Active = r_tx_active;
  assign o_Tx_Done   = r_tx_done;

endmodule : uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 435, meaning clocks per serial bit (legal range 2..2047).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit byte buffer entries (power of two, 2..16).
REQ-003 SHALL have port i_Clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_Tx_DV  input  1  write strobe; byte accepted on a rising edge where i_Tx_DV=1 and o_Tx_Ready=1.
REQ-006 SHALL have port i_Tx_Byte  input  8  byte to transmit, sampled with i_Tx_DV.
REQ-007 SHALL have port o_Tx_Ready  output  1  high when the buffer holds fewer than FIFO_DEPTH bytes.
REQ-008 SHALL have port o_Tx_Serial  output  1  serial line, registered, idle high.
REQ-009 SHALL have port o_Tx_Active  output  1  high from the first start-bit cycle through the last stop-bit cycle of each frame.
REQ-010 SHALL have port o_Tx_Done  output  1  one-cycle pulse after each completed stop bit.
REQ-011 SHALL have port o_Fifo_Count  output  clog2(FIFO_DEPTH)+1  number of buffered (not yet started) bytes.

Function
REQ-012 Frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 Each bit SHALL be held on o_Tx_Serial for exactly CLKS_PER_BIT cycles; bit counter width clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, CLEANUP; any unused encoding SHALL return to IDLE on the next edge.
REQ-015 IDLE: line high; if the buffer is non-empty, pop head byte into the shift register, enter START, drive line low from that edge.
REQ-016 START -> DATA after CLKS_PER_BIT cycles; DATA advances bit index 0..7 every CLKS_PER_BIT cycles, -> STOP after bit 7.
REQ-017 STOP: line high for CLKS_PER_BIT cycles, then -> CLEANUP with o_Tx_Done=1 and o_Tx_Active=0.
REQ-018 CLEANUP SHALL last exactly 1 cycle, line high, then -> IDLE; minimum inter-frame idle therefore 2 cycles (CLEANUP + IDLE).
REQ-019 Latency: byte written at edge E into an empty buffer with FSM in IDLE SHALL produce start bit on o_Tx_Serial from edge E+1.
REQ-020 Write while o_Tx_Ready=0 SHALL be ignored (byte dropped, count unchanged), even if a pop occurs the same cycle.
REQ-021 Simultaneous accepted write and pop SHALL leave o_Fifo_Count unchanged and preserve FIFO order.
REQ-022 o_Tx_Ready and o_Fifo_Count SHALL reflect state after the current edge's push/pop (registered, no combinational path from i_Tx_DV).
REQ-023 Buffer pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by count, never by pointer equality alone.
REQ-024 i_Tx_Byte changes during an active frame SHALL not affect the frame in flight.

Reset
REQ-025 While i_Rst_n=0 at a rising edge: FSM=IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, counters and pointers 0.
REQ-026 Reset mid-frame SHALL abort the frame (line high at the next edge) and discard all buffered bytes; no o_Tx_Done pulse.
REQ-027 Writes presented during reset SHALL be ignored.

Structure
REQ-028 FSM state encodings and the frame bit count (8) SHALL live in shared package uart_pkg, also usable by the receiver.
REQ-029 The buffer SHALL be a separate sub-module uart_tx_fifo (synchronous, registered count, push/pop/full/empty).
REQ-030 Total RTL SHALL be 120-400 lines; no vendor primitives.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
REQ-031 Write 0xA5 once from idle -> line low from next edge for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles, o_Tx_Done pulse 1 cycle, 40 cycles of o_Tx_Active.
REQ-032 Write 0x00,0xFF,0x55,0x0F on 4 consecutive cycles -> o_Fifo_Count peaks at 3 or 4, four back-to-back frames in order, each separated by exactly 2 idle-high cycles, 4 Done pulses.
REQ-033 Write 6 bytes on 6 consecutive cycles -> first 5 accepted (1 popped + 4 buffered), o_Tx_Ready=0 on cycle 6, sixth byte never transmitted.
REQ-034 Assert i_Rst_n=0 for 1 cycle in DATA bit 3 with 2 bytes buffered -> line high next edge, count=0, Ready=1, no Done, no further frames.
REQ-035 Write at the exact edge the FSM pops with count=1 -> count stays 1, both bytes transmitted in order.
REQ-036 CLKS_PER_BIT=435: frame of 0x3C -> each bit exactly 435 cycles, total frame 4350 cycles, measured by a receive-side checker.
